// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin valid/ready front end sharing one ALU between two requesters.
// One op in flight; illegal opcodes and divide-by-zero are answered locally without touching the ALU.
module alu_arbiter #(
   parameter int WIDTH   = 16,
   parameter int FUN_W   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [FUN_W-1:0] req0_fun,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [FUN_W-1:0] req1_fun,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic [4:0]       rsp_flags,
   output logic             rsp_err,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [FUN_W-1:0] alu_fun,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   input  logic             alu_arith,
   input  logic             alu_logic,
   input  logic             alu_cmp,
   input  logic             alu_shift
);
   localparam int CW = $clog2(ALU_LAT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t          state;
   logic            last;
   logic [CW-1:0]   cnt;
   logic            win, grant, bad_fun, div0;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [FUN_W-1:0] sel_fun;
   // Contention goes to whichever requester was not granted last
   assign win     = (req0_valid & req1_valid) ? ~last : req1_valid;
   assign grant   = rst_n & (state == IDLE) & (req0_valid | req1_valid);
   assign req0_ready = grant & ~win;
   assign req1_ready = grant & win;
   assign sel_a   = win ? req1_a : req0_a;
   assign sel_b   = win ? req1_b : req0_b;
   assign sel_fun = win ? req1_fun : req0_fun;
   assign bad_fun = sel_fun == {FUN_W{1'b1}};
   assign div0    = (sel_fun == FUN_W'(3)) & (sel_b == '0);
   assign busy    = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= '1;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (grant) begin
               last   <= win;
               rsp_id <= win;
               if (bad_fun | div0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= bad_fun ? '0 : '1;
                  rsp_flags <= '0;
               end else begin
                  state   <= ISSUE;
                  rsp_err <= 1'b0;
                  alu_a   <= sel_a;
                  alu_b   <= sel_b;
                  alu_fun <= sel_fun;
               end
            end
            ISSUE: begin
               state     <= WAIT;
               cnt       <= CW'(ALU_LAT - 1);
               rsp_flags <= {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift};
            end
            WAIT: if (cnt == '0) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= alu_out;
               alu_a     <= '0;
               alu_b     <= '0;
               alu_fun   <= '1;
            end else begin
               cnt <= cnt - 1'b1;
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
